fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 175 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Fetches one word at a time from an upstream FIFO and sends it as an
//   8N1-style UART frame: a start bit (0), DATA_WIDTH data bits LSB first,
//   and one stop bit (1). Each bit lasts CLKS_PER_BIT clk cycles.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-low reset
//   enable       : permits fetching a new word while idle
//   fifo_rd_en   : one-cycle read request to the FIFO
//   fifo_rd_data : FIFO read data, sampled only in the WAIT state
//   fifo_rd_val  : FIFO read-data-valid, sampled only in the WAIT state
//   tx           : serial line, idle high
//   busy         : high from the read request until the end of the stop bit
//   frame_done   : one-cycle pulse in the last cycle of the stop bit
//   state_dbg    : current FSM state (encoding of state_t)
//
// FIFO read handshake: fifo_rd_en is high for exactly one cycle (REQ). The
// FIFO answers in the following cycle (WAIT) by driving fifo_rd_val and
// fifo_rd_data; fifo_rd_val=0 in WAIT means the FIFO was empty and the
// attempt is abandoned. Nothing on the FIFO inputs is looked at elsewhere.
//
// All outputs are registered: each output register is loaded from the value
// the combinational logic computes for the state being entered.

module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_val,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [2:0]            state_dbg
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [BAUD_W-1:0]     baud_cnt, baud_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  baud_wrap;
  logic                  tx_nxt, rd_en_nxt, busy_nxt, done_nxt;

  // Cleared by reset, set on the first edge afterwards. A fetch can only
  // start from IDLE once this is set, so the first read request after reset
  // release lands no earlier than the second rising edge with enable high.
  logic armed;

  assign state_dbg = state;
  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // ---------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      armed      <= 1'b0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      armed      <= 1'b1;
      tx         <= tx_nxt;
      fifo_rd_en <= rd_en_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state, counters, shift register
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;

    case (state)
      ST_IDLE: begin
        if (enable && armed) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (fifo_rd_val) begin
          shreg_nxt = fifo_rd_data;
          state_nxt = ST_START;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_wrap) begin
          state_nxt = ST_DATA;
          bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        // The bit on the line is always shreg[0]; shift at the end of each bit.
        if (baud_wrap) begin
          shreg_nxt = shreg >> 1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = ST_STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (baud_wrap) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Baud counter restarts at 0 on every state entry and wraps inside the
  // timed states, so a DATA->DATA bit change also restarts it.
  always_comb begin
    baud_nxt = '0;
    if (state_nxt == state) begin
      if ((state == ST_START) || (state == ST_DATA) || (state == ST_STOP)) begin
        baud_nxt = baud_wrap ? '0 : baud_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output values for the state being entered
  // ---------------------------------------------------------------------
  always_comb begin
    tx_nxt    = 1'b1;
    rd_en_nxt = 1'b0;
    busy_nxt  = (state_nxt != ST_IDLE);
    done_nxt  = 1'b0;
    case (state_nxt)
      ST_REQ:   rd_en_nxt = 1'b1;
      ST_START: tx_nxt    = 1'b0;
      ST_DATA:  tx_nxt    = shreg_nxt[0];
      ST_STOP:  done_nxt  = (baud_nxt == BAUD_LAST);
      default:  tx_nxt    = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Self-checking bench for fifo_uart_tx with DATA_WIDTH=8, CLKS_PER_BIT=4.
//   A FIFO model answers read requests one cycle later; every word loaded
//   into it is also pushed to exp_q, and a line monitor decodes each frame on
//   tx and pops exp_q to compare.

module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int FRAME_CYCLES = (DW + 2) * CPB;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          reset;
  logic          enable;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_val;
  logic          tx;
  logic          busy;
  logic          frame_done;
  logic [2:0]    state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_val (fifo_rd_val),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done),
    .state_dbg   (state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- FIFO model + scoreboard queue ----------------
  logic [DW-1:0] fifo_mem[$];
  logic [DW-1:0] exp_q[$];
  bit            req_seen = 1'b0;

  task automatic push_word(input logic [DW-1:0] w);
    fifo_mem.push_back(w);
    exp_q.push_back(w);
  endtask

  always @(negedge clk) req_seen = fifo_rd_en;

  // Data answers in the cycle after the request; at all other times the
  // data bus carries random junk so any leak into tx is caught.
  always @(posedge clk) begin
    #1;
    if (reset && req_seen && fifo_mem.size() > 0) begin
      fifo_rd_val  = 1'b1;
      fifo_rd_data = fifo_mem.pop_front();
    end else begin
      fifo_rd_val  = 1'b0;
      fifo_rd_data = DW'($urandom_range(0, (1 << DW) - 1));
    end
    req_seen = 1'b0;
  end

  // ---------------- event counters ----------------
  int rd_en_count  = 0;
  int rd_gap       = 0;
  int last_rd_cyc  = -100;
  int double_rd    = 0;
  int done_total   = 0;
  bit prev_rd      = 1'b0;

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_en_count++;
      rd_gap      = cyc - last_rd_cyc;
      last_rd_cyc = cyc;
      if (prev_rd) double_rd++;
    end
    prev_rd = fifo_rd_en;
    if (frame_done) done_total++;
  end

  // ---------------- line monitor ----------------
  int frames_started = 0;
  int frames_seen    = 0;
  int last_end_cyc   = -1;
  int last_gap       = -1;

  task automatic capture_frame();
    logic [DW+1:0] bits;
    logic [DW-1:0] w;
    int  shape_err;
    int  done_hits;
    int  done_last;
    int  start_cyc;
    bit  aborted;
    shape_err = 0;
    done_hits = 0;
    done_last = 0;
    aborted   = 1'b0;
    bits      = '0;
    start_cyc = cyc;
    frames_started++;
    for (int b = 0; b < DW + 2; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (!reset) begin
          aborted = 1'b1;
          break;
        end
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) shape_err++;
        if (frame_done) begin
          done_hits++;
          if (b == DW + 1 && c == CPB - 1) done_last = 1;
        end
      end
      if (aborted) break;
    end
    if (aborted) return;
    if (last_end_cyc >= 0) last_gap = start_cyc - last_end_cyc - 1;
    last_end_cyc = cyc;
    w = bits[DW:1];
    check("frame_bit_hold", shape_err, 0);
    check("frame_stop_bit", bits[DW+1], 1'b1);
    check("frame_done_count", done_hits, 1);
    check("frame_done_last", done_last, 1);
    if (exp_q.size() == 0) begin
      check("unexpected_frame", w, 32'hFFFF_FFFF);
    end else begin
      check("frame_data", w, exp_q.pop_front());
    end
    frames_seen++;
    @(negedge clk);
    check("post_frame_busy", busy, 1'b0);
    check("post_frame_tx", tx, 1'b1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset && tx == 1'b0) capture_frame();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_wait_timeout", frames_seen >= target, 1);
  endtask

  task automatic wait_start(input int target, input int budget);
    int n = 0;
    while (frames_started < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("start_wait_timeout", frames_started >= target, 1);
  endtask

  // ---------------- stimulus ----------------
  int rd0, d0, f0, s0, cnt;

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    wait_cycles(3);

    // Reset state
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_state", state_dbg, 3'd0);

    // Single word 0xA5, with release-guard and fetch latency checks
    push_word(8'hA5);
    rd0 = rd_en_count;
    reset  = 1'b1;
    enable = 1'b1;
    wait_cycles(1);
    check("guard_no_rd_first_edge", fifo_rd_en, 1'b0);
    wait_cycles(1);
    check("req_rd_en", fifo_rd_en, 1'b1);
    check("req_busy", busy, 1'b1);
    check("req_tx", tx, 1'b1);
    enable = 1'b0;
    wait_cycles(1);
    check("wait_rd_en", fifo_rd_en, 1'b0);
    check("wait_tx", tx, 1'b1);
    check("wait_busy", busy, 1'b1);
    wait_cycles(1);
    check("start_tx", tx, 1'b0);
    wait_frames(1, FRAME_CYCLES + 20);
    wait_cycles(10);
    check("single_rd_pulses", rd_en_count - rd0, 1);

    // Empty FIFO: repeated requests every third cycle, nothing sent
    rd0 = rd_en_count;
    d0  = done_total;
    f0  = frames_started;
    enable = 1'b1;
    wait_cycles(30);
    enable = 1'b0;
    wait_cycles(5);
    cnt = rd_en_count - rd0;
    check("empty_rd_count_range", (cnt >= 9 && cnt <= 11), 1);
    check("empty_rd_spacing", rd_gap, 3);
    check("empty_no_frame_done", done_total - d0, 0);
    check("empty_no_frame", frames_started - f0, 0);
    check("empty_idle_busy", busy, 1'b0);

    // Back-to-back 0x00 then 0xFF
    push_word(8'h00);
    push_word(8'hFF);
    f0 = frames_seen;
    enable = 1'b1;
    wait_frames(f0 + 2, 2 * FRAME_CYCLES + 40);
    enable = 1'b0;
    check("b2b_gap", last_gap, 3);
    wait_cycles(8);

    // Enable dropped 5 cycles into the 0x3C frame
    push_word(8'h3C);
    s0 = frames_started;
    f0 = frames_seen;
    enable = 1'b1;
    wait_start(s0 + 1, 20);
    wait_cycles(5);
    enable = 1'b0;
    wait_frames(f0 + 1, FRAME_CYCLES + 20);
    rd0 = rd_en_count;
    wait_cycles(20);
    check("drop_no_more_rd", rd_en_count - rd0, 0);

    // Reset during data bit 3; the partial word is dropped
    push_word(8'h11);
    s0 = frames_started;
    enable = 1'b1;
    wait_start(s0 + 1, 20);
    wait_cycles(17);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rd_en", fifo_rd_en, 1'b0);
    check("midrst_state", state_dbg, 3'd0);
    void'(exp_q.pop_front());
    push_word(8'h96);
    f0 = frames_seen;
    wait_cycles(2);
    reset = 1'b1;
    wait_frames(f0 + 1, FRAME_CYCLES + 20);
    enable = 1'b0;
    wait_cycles(8);

    // Data isolation: bus toggles randomly during the 0x5A frame
    push_word(8'h5A);
    f0 = frames_seen;
    enable = 1'b1;
    wait_start(frames_started + 1, 20);
    enable = 1'b0;
    wait_frames(f0 + 1, FRAME_CYCLES + 20);
    wait_cycles(5);

    // Final report
    check("scoreboard_empty", exp_q.size(), 0);
    check("fifo_drained", fifo_mem.size(), 0);
    check("no_double_rd", double_rd, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
